// File: rtl/av2_itx_pkg.sv
// Shared types and size rules for the inverse-transform scheduler.
// Holds the FSM encoding and the transform-size legality check.
package av2_itx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] SZ_4  = 6'd3;
    localparam logic [5:0] SZ_8  = 6'd7;
    localparam logic [5:0] SZ_16 = 6'd15;
    localparam logic [5:0] SZ_32 = 6'd31;
    localparam logic [5:0] SZ_64 = 6'd63;

    localparam int unsigned ASPECT_MAX = 4;

    function automatic logic code_ok(input logic [5:0] c);
        return (c == SZ_4) || (c == SZ_8) || (c == SZ_16) ||
               (c == SZ_32) || (c == SZ_64);
    endfunction

    // Sizes arrive as dimension-1; compare real dimensions against the limits.
    function automatic logic size_legal(
        input logic [5:0]  w,
        input logic [5:0]  h,
        input int unsigned max_sz
    );
        int unsigned dw;
        int unsigned dh;
        int unsigned lo;
        int unsigned hi;
        dw = 32'(w) + 32'd1;
        dh = 32'(h) + 32'd1;
        lo = (dw < dh) ? dw : dh;
        hi = (dw < dh) ? dh : dw;
        return code_ok(w) && code_ok(h) &&
               (dw <= max_sz) && (dh <= max_sz) &&
               (hi <= lo * ASPECT_MAX);
    endfunction

endpackage

// File: rtl/av2_itx_sched_arb.sv
// Two-way round-robin arbiter for the transform scheduler.
// prio_q names the port that wins a tie; it moves only on a grant.
module av2_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                grant_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_o[0]) begin
            prio_d = 1'b1;
        end else if (grant_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/av2_itx_sched.sv
// Job sequencer for the shared inverse-transform datapath.
// Arbitrates two requesters, issues jobs, times out and reports completions.
module av2_itx_sched
    import av2_itx_pkg::*;
#(
    parameter int unsigned MAX_TX_SIZE    = 64,
    parameter int          TAG_W          = 8,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [11:0]        req_tx_width,
    input  logic [11:0]        req_tx_height,
    input  logic [7:0]         req_tx_type,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic               itx_start,
    output logic [5:0]         itx_tx_width,
    output logic [5:0]         itx_tx_height,
    output logic [3:0]         itx_tx_type,
    input  logic               itx_valid,
    output logic               itx_ready,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               done_req_id,
    output logic [TAG_W-1:0]   done_tag,
    output logic               done_error,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic             stale_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [5:0]       w_q;
    logic [5:0]       h_q;
    logic [3:0]       type_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic             err_q;
    logic [7:0]       errcnt_q;
    logic [7:0]       errcnt_d;

    logic             arb_en;
    logic [1:0]       grant;
    logic             accept;
    logic             gnt_id;
    logic [5:0]       sel_w;
    logic [5:0]       sel_h;
    logic [3:0]       sel_type;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_legal;

    // Gate on rst_n so req_ready reads zero while reset is held.
    assign arb_en = rst_n && (state_q == S_IDLE) && !stale_q;

    av2_rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arb_en),
        .valid_i (req_valid),
        .grant_o (grant)
    );

    assign accept    = |grant;
    assign gnt_id    = grant[1];
    assign sel_w     = gnt_id ? req_tx_width[11:6]  : req_tx_width[5:0];
    assign sel_h     = gnt_id ? req_tx_height[11:6] : req_tx_height[5:0];
    assign sel_type  = gnt_id ? req_tx_type[7:4]    : req_tx_type[3:0];
    assign sel_tag   = gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    assign sel_legal = size_legal(sel_w, sel_h, MAX_TX_SIZE);

    assign cnt_d    = cnt_q + CNT_W'(1);
    assign errcnt_d = (&errcnt_q) ? errcnt_q : errcnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stale_q  <= 1'b0;
            cnt_q    <= '0;
            w_q      <= '0;
            h_q      <= '0;
            type_q   <= '0;
            tag_q    <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            // A late result after a timeout is swallowed here.
            if (stale_q && itx_valid) begin
                stale_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        w_q    <= sel_w;
                        h_q    <= sel_h;
                        type_q <= sel_type;
                        tag_q  <= sel_tag;
                        id_q   <= gnt_id;
                        if (sel_legal) begin
                            err_q   <= 1'b0;
                            state_q <= S_ISSUE;
                        end else begin
                            err_q    <= 1'b1;
                            errcnt_q <= errcnt_d;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (itx_valid) begin
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_q    <= 1'b1;
                        errcnt_q <= errcnt_d;
                        stale_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = grant;
    assign itx_start     = (state_q == S_ISSUE);
    assign itx_ready     = (state_q == S_WAIT) || stale_q;
    assign itx_tx_width  = w_q;
    assign itx_tx_height = h_q;
    assign itx_tx_type   = type_q;
    assign done_valid    = (state_q == S_DONE);
    assign done_req_id   = id_q;
    assign done_tag      = tag_q;
    assign done_error    = err_q;
    assign busy          = (state_q != S_IDLE);
    assign err_count     = errcnt_q;

endmodule

// File: tb/tb_av2_itx_sched.sv
// Directed bench for av2_itx_sched with a 16-cycle timeout.
// Inputs change 2 time units after each rising edge; outputs sampled there.
module tb_av2_itx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [11:0] req_tx_width = '0;
    logic [11:0] req_tx_height = '0;
    logic [7:0]  req_tx_type = '0;
    logic [15:0] req_tag = '0;
    logic        itx_start;
    logic [5:0]  itx_tx_width;
    logic [5:0]  itx_tx_height;
    logic [3:0]  itx_tx_type;
    logic        itx_valid = 1'b0;
    logic        itx_ready;
    logic        done_valid;
    logic        done_ready = 1'b1;
    logic        done_req_id;
    logic [7:0]  done_tag;
    logic        done_error;
    logic        busy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    av2_itx_sched #(
        .MAX_TX_SIZE    (64),
        .TAG_W          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tx_width  (req_tx_width),
        .req_tx_height (req_tx_height),
        .req_tx_type   (req_tx_type),
        .req_tag       (req_tag),
        .itx_start     (itx_start),
        .itx_tx_width  (itx_tx_width),
        .itx_tx_height (itx_tx_height),
        .itx_tx_type   (itx_tx_type),
        .itx_valid     (itx_valid),
        .itx_ready     (itx_ready),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_req_id   (done_req_id),
        .done_tag      (done_tag),
        .done_error    (done_error),
        .busy          (busy),
        .err_count     (err_count)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        itx_valid  = 1'b0;
        done_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int p, input logic [5:0] w,
                           input logic [5:0] h, input logic [3:0] t,
                           input logic [7:0] tag);
        req_tx_width[p*6 +: 6]  = w;
        req_tx_height[p*6 +: 6] = h;
        req_tx_type[p*4 +: 4]   = t;
        req_tag[p*8 +: 8]       = tag;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        step();
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        checks++;
        if ({itx_start, itx_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: start/ready/busy=%b want 000",
                     {itx_start, itx_ready, busy});
        end
        checks++;
        if ({itx_tx_width, itx_tx_height, itx_tx_type} !== 16'h0) begin
            errors++;
            $display("FAIL reset_tx: got %h want 0000",
                     {itx_tx_width, itx_tx_height, itx_tx_type});
        end
        checks++;
        if ({done_valid, done_req_id, done_tag, done_error} !== 11'h0) begin
            errors++;
            $display("FAIL reset_done: got %h want 000",
                     {done_valid, done_req_id, done_tag, done_error});
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
        req_valid = 2'b00;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_req(0, 6'd7, 6'd7, 4'd2, 8'h11);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (itx_start !== 1'b1 || itx_tx_width !== 6'd7 ||
            itx_tx_height !== 6'd7 || itx_tx_type !== 4'd2) begin
            errors++;
            $display("FAIL single_issue: start=%b w=%0d h=%0d t=%0d want 1 7 7 2",
                     itx_start, itx_tx_width, itx_tx_height, itx_tx_type);
        end
        step();
        checks++;
        if (itx_start !== 1'b0 || itx_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: start=%b ready=%b busy=%b want 0 1 1",
                     itx_start, itx_ready, busy);
        end
        repeat (5) step();
        itx_valid = 1'b1;
        step();
        itx_valid = 1'b0;
        checks++;
        if (done_valid !== 1'b1 || done_tag !== 8'h11 ||
            done_req_id !== 1'b0 || done_error !== 1'b0) begin
            errors++;
            $display("FAIL single_done: v=%b tag=%h id=%b err=%b want 1 11 0 0",
                     done_valid, done_tag, done_req_id, done_error);
        end
        step();
        checks++;
        if (done_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: v=%b busy=%b want 0 0", done_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic       ids[4];
        logic [7:0] tgs[4];
        int         n = 0;
        int         both = 0;
        do_reset();
        set_req(0, 6'd3, 6'd3, 4'd0, 8'hA0);
        set_req(1, 6'd3, 6'd3, 4'd1, 8'hB0);
        req_valid = 2'b11;
        for (int c = 0; c < 200 && n < 4; c++) begin
            #1;
            if (req_ready == 2'b11) both++;
            if (done_valid) begin
                ids[n] = done_req_id;
                tgs[n] = done_tag;
                n++;
            end
            itx_valid = itx_ready;
            step();
        end
        req_valid = 2'b00;
        itx_valid = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_timeout: got %0d completions want 4", n);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL contention_onehot: req_ready=11 seen %0d times want 0", both);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ids[i] !== i[0] || tgs[i] !== (i[0] ? 8'hB0 : 8'hA0)) begin
                errors++;
                $display("FAIL contention_order[%0d]: id=%b tag=%h want %b %h",
                         i, ids[i], tgs[i], i[0], i[0] ? 8'hB0 : 8'hA0);
            end
        end
        step();
    endtask

    task automatic test_illegal();
        do_reset();
        set_req(0, 6'd3, 6'd31, 4'd1, 8'h21);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL illegal_grant: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (done_valid !== 1'b1 || done_error !== 1'b1 || itx_start !== 1'b0 ||
            err_count !== 8'd1 || done_tag !== 8'h21) begin
            errors++;
            $display("FAIL illegal_ratio: v=%b err=%b start=%b cnt=%0d tag=%h want 1 1 0 1 21",
                     done_valid, done_error, itx_start, err_count, done_tag);
        end
        step();
        checks++;
        if (busy !== 1'b0 || itx_start !== 1'b0) begin
            errors++;
            $display("FAIL illegal_idle: busy=%b start=%b want 0 0", busy, itx_start);
        end
        set_req(1, 6'd4, 6'd7, 4'd1, 8'h22);
        req_valid = 2'b10;
        #1;
        step();
        req_valid = 2'b00;
        checks++;
        if (done_valid !== 1'b1 || done_error !== 1'b1 || done_req_id !== 1'b1 ||
            err_count !== 8'd2 || itx_start !== 1'b0) begin
            errors++;
            $display("FAIL illegal_code: v=%b err=%b id=%b cnt=%0d start=%b want 1 1 1 2 0",
                     done_valid, done_error, done_req_id, err_count, itx_start);
        end
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        set_req(0, 6'd15, 6'd15, 4'd3, 8'h33);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        for (int i = 0; i < 16; i++) begin
            if (done_valid !== 1'b0 || itx_ready !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d bad WAIT cycles want 0", bad);
        end
        checks++;
        if (done_valid !== 1'b1 || done_error !== 1'b1 || done_tag !== 8'h33 ||
            itx_ready !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_done: v=%b err=%b tag=%h rdy=%b cnt=%0d want 1 1 33 1 1",
                     done_valid, done_error, done_tag, itx_ready, err_count);
        end
        step();
        set_req(1, 6'd7, 6'd7, 4'd0, 8'h44);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_block: req_ready=%b busy=%b want 00 0", req_ready, busy);
        end
        step();
        itx_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00 || itx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stale: req_ready=%b itx_ready=%b want 00 1",
                     req_ready, itx_ready);
        end
        step();
        itx_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10 || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_absorb: req_ready=%b done_valid=%b want 10 0",
                     req_ready, done_valid);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (itx_start !== 1'b1 || itx_tx_width !== 6'd7) begin
            errors++;
            $display("FAIL timeout_next_issue: start=%b w=%0d want 1 7",
                     itx_start, itx_tx_width);
        end
        step();
        itx_valid = 1'b1;
        step();
        itx_valid = 1'b0;
        checks++;
        if (done_valid !== 1'b1 || done_error !== 1'b0 || done_req_id !== 1'b1 ||
            done_tag !== 8'h44 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_next_done: v=%b err=%b id=%b tag=%h cnt=%0d want 1 0 1 44 1",
                     done_valid, done_error, done_req_id, done_tag, err_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        done_ready = 1'b0;
        set_req(0, 6'd31, 6'd7, 4'd5, 8'h55);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        checks++;
        if (itx_start !== 1'b1) begin
            errors++;
            $display("FAIL bp_issue: start=%b want 1", itx_start);
        end
        step();
        itx_valid = 1'b1;
        step();
        itx_valid = 1'b0;
        set_req(1, 6'd7, 6'd7, 4'd0, 8'h66);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ({done_valid, done_tag, done_req_id, done_error, busy, req_ready} !==
                {1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 2'b00}) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        done_ready = 1'b1;
        #1;
        checks++;
        if (done_valid !== 1'b1 || done_tag !== 8'h55) begin
            errors++;
            $display("FAIL bp_release: v=%b tag=%h want 1 55", done_valid, done_tag);
        end
        step();
        #1;
        checks++;
        if (done_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_after: v=%b busy=%b req_ready=%b want 0 0 10",
                     done_valid, busy, req_ready);
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_wait();
        set_req(0, 6'd7, 6'd15, 4'd1, 8'h77);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        checks++;
        if (itx_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_entry: rdy=%b busy=%b want 1 1", itx_ready, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, itx_ready, itx_start, done_valid, req_ready} !== 6'b0 ||
            {itx_tx_width, itx_tx_height, itx_tx_type, done_tag} !== 24'h0) begin
            errors++;
            $display("FAIL rst_async: busy=%b rdy=%b w=%0d h=%0d tag=%h want all 0",
                     busy, itx_ready, itx_tx_width, itx_tx_height, done_tag);
        end
        step();
        step();
        rst_n = 1'b1;
        set_req(1, 6'd15, 6'd15, 4'd6, 8'h88);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rst_regrant: got %b want 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (itx_start !== 1'b1 || itx_tx_width !== 6'd15 || itx_tx_type !== 4'd6) begin
            errors++;
            $display("FAIL rst_issue: start=%b w=%0d t=%0d want 1 15 6",
                     itx_start, itx_tx_width, itx_tx_type);
        end
        step();
        itx_valid = 1'b1;
        step();
        itx_valid = 1'b0;
        checks++;
        if (done_valid !== 1'b1 || done_req_id !== 1'b1 || done_tag !== 8'h88 ||
            done_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: v=%b id=%b tag=%h err=%b want 1 1 88 0",
                     done_valid, done_req_id, done_tag, done_error);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/av2_itx_sched.md
# av2_itx_sched

Sequencer and arbiter for the shared inverse-transform datapath. It accepts transform-block jobs from two requesters (port 0 luma, port 1 chroma) and grants them round-robin. For each granted job it checks size legality, drives the transform's start and parameters, waits for the result with a timeout, and reports completion with the job's tag and an error flag to the reconstruction stage.

## Interface
- MAX_TX_SIZE, 64, largest legal transform dimension in pixels
- TAG_W, 8, job tag width
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before a job is declared failed
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  2  per-requester job valid
- req_ready  out  2  per-requester grant; one-hot or zero
- req_tx_width  in  12  2×6b; size−1 encoding (3,7,15,31,63)
- req_tx_height  in  12  2×6b; same encoding
- req_tx_type  in  8  2×4b transform type
- req_tag  in  2*TAG_W  per-requester tag
- itx_start  out  1  one-cycle start pulse to the transform
- itx_tx_width / itx_tx_height  out  6  latched job size
- itx_tx_type  out  4  latched job type
- itx_valid  in  1  transform result valid; held until itx_ready
- itx_ready  out  1  scheduler accepts the result
- done_valid  out  1  completion valid; held until done_ready
- done_ready  in  1  downstream accepts the completion
- done_req_id  out  1  requester of the completed job
- done_tag  out  TAG_W  tag of the completed job
- done_error  out  1  job was illegal or timed out
- busy  out  1  FSM not in IDLE
- err_count  out  8  saturating count of errored jobs

## Operation
- FSM states:
  - IDLE, on a grant: to ISSUE if the size is legal, else to DONE with error.
  - ISSUE → WAIT after one cycle.
  - WAIT → DONE on itx handshake, or on timeout with error.
  - DONE → IDLE on done_valid & done_ready.
- Arbitration happens only in IDLE with stale_pending=0. req_ready is combinational from req_valid and the rr pointer.
  - If both requesters are valid, the one not last granted wins. If only one is valid, it wins.
  - The pointer updates only on an accepted grant. After reset the pointer favours port 0.
- The descriptor (size, type, tag, id) is latched on req_valid & req_ready. itx_tx_* hold the latched values from ISSUE until the next grant.
- Legal size: width+1 and height+1 are each in {4,8,16,32,64}, each ≤ MAX_TX_SIZE, and max/min ≤ 4. An illegal job never pulses itx_start.
- itx_start=1 only in ISSUE. itx_ready=1 in WAIT, or whenever stale_pending=1.
- Timeout: the counter clears on entry to WAIT. When it reaches TIMEOUT_CYCLES−1 without itx_valid, go to DONE with error and set stale_pending.
  - stale_pending clears on the next itx_valid, which is consumed and discarded, not reported.
  - While stale_pending=1 no grant is issued.
- err_count increments on DONE entry when done_error=1 and saturates at 255.
- done_* are stable while done_valid=1 && !done_ready.

## Timing
- Reset values: req_ready=0, itx_start=0, itx_ready=0, itx_tx_*=0, done_valid=0, done_req_id=0, done_tag=0, done_error=0, busy=0, err_count=0. FSM=IDLE, rr pointer=port 0, stale_pending=0, timeout counter=0.
- Grant in cycle N; itx_start in cycle N+1; WAIT from N+2.
- An itx handshake in cycle M gives done_valid=1 from cycle M+1.
- An illegal job granted in N gives done_valid=1 in N+1.
- A done handshake in cycle K returns the FSM to IDLE at K+1. The next grant is possible in K+1, so there is no back-to-back grant.
- If itx_valid and the timeout fall in the same cycle, the handshake wins and there is no error.
- Reset asserted mid-job forces every output to its reset value immediately; any in-flight transform result is not tracked.

## Structure
- Shared package av2_itx_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE)
  - legal size-code constants (3, 7, 15, 31, 63)
  - the aspect-ratio limit (4)
  - the legality function
- One sub-module: av2_rr_arbiter2, a 2-way round-robin grant with a pointer update on accept.

## Test plan
- Single legal job: port 0, 8×8 (7,7), type 2, tag 0x11; transform replies after 6 cycles → itx_start in N+1; done_tag=0x11, done_req_id=0, done_error=0.
- Contention: both ports valid continuously with tags 0xA0 and 0xB0 → completions alternate 0,1,0,1; req_ready is never 2'b11.
- Illegal sizes: 4×32 (3,31), ratio 8 → no itx_start; done_error=1 at N+1; err_count=1. Repeat with 5×8 (4,7) → err_count=2.
- Timeout: TIMEOUT_CYCLES=16, transform silent → done_error=1 after 16 WAIT cycles. A late itx_valid is absorbed with no completion reported. A new request waits until the stale result is absorbed.
- Backpressure: done_ready=0 for 10 cycles → done_* stable; busy=1; req_ready=0; completion accepted on the first cycle done_ready=1.
- Reset mid-WAIT → all outputs take their reset values at once; after release a port 1 job is granted normally.
